fifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the asynchronous FIFO manager, in its read clock domain. It turns the FIFO's fixed-latency read interface (read strobe in, data-valid returned RD_LATENCY cycles later) into a valid/ready stream. A credit counter and a small circular skid buffer guarantee that every issued read has a buffer slot, so the stream never drops data and sustains one word per cycle when the sink is ready.

---
 rtl/fifo_rd_stream_if.sv | 26 ++
 rtl/fifo_rd_stream.sv | 121 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Purpose: FIFO read-side and stream-side signal bundle for fifo_rd_stream.
// Latency: none, wires only.
// Backpressure: carried by i_tready on the stream side; the FIFO side is a strobe with fixed-latency return.
// Modports: slave = adapter view (fifo_rd_stream); master = FIFO + stream sink view.
// Signal prefixes give direction as seen from the adapter.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 512
);
    logic                  o_fifo_rd;
    logic                  i_empty;
    logic [DATA_WIDTH-1:0] i_fifo_data;
    logic                  i_fifo_rddata_vld;
    logic [DATA_WIDTH-1:0] o_tdata;
    logic                  o_tvalid;
    logic                  i_tready;

    modport slave (
        input  i_empty, i_fifo_data, i_fifo_rddata_vld, i_tready,
        output o_fifo_rd, o_tdata, o_tvalid
    );

    modport master (
        output i_empty, i_fifo_data, i_fifo_rddata_vld, i_tready,
        input  o_fifo_rd, o_tdata, o_tvalid
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Purpose: turns a fixed-latency FIFO read port into a valid/ready stream via credits + circular skid buffer.
// Latency: read strobe to o_tvalid is RD_LATENCY+1 cycles; one word per cycle sustained when BUF_DEPTH >= RD_LATENCY+2.
// Backpressure: reads stop once inflight+level reaches BUF_DEPTH, so every returned word always has a slot.
// Ports:
//   i_clk, i_rst_n    FIFO read clock, async active-low reset
//   i_enable          gates new read issue only
//   bus (slave)       o_fifo_rd / i_empty / i_fifo_data / i_fifo_rddata_vld, o_tdata / o_tvalid / i_tready
//   o_level           words held in the skid buffer
//   o_inflight        reads issued and not yet returned
//   o_error_unexp     sticky: data-valid with no read outstanding
//   o_error_ovf       sticky: data-valid into a full buffer with no pop that cycle (word dropped)
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 512,
    parameter int RD_LATENCY = 3,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    fifo_rd_stream_if.slave              bus,
    output logic [$clog2(BUF_DEPTH):0]   o_level,
    output logic [$clog2(BUF_DEPTH):0]   o_inflight,
    output logic                         o_error_unexp,
    output logic                         o_error_ovf
);
    // BUF_DEPTH must be a power of two (pointers wrap naturally) and at least 2.
    localparam int             PW      = $clog2(BUF_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);

    // Credits cover any return delay, so the logic itself is latency-agnostic;
    // RD_LATENCY only determines the depth needed for full throughput.
    logic w_unused_rd_latency;
    assign w_unused_rd_latency = (RD_LATENCY > 0);

    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_level;
    logic [CW-1:0]         r_inflight;
    logic                  r_err_unexp;
    logic                  r_err_ovf;

    logic [CW:0]           w_committed;
    logic                  w_issue;
    logic                  w_vld;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_ovf;

    // Slots already promised: words held plus words still on their way back.
    assign w_committed = {1'b0, r_inflight} + {1'b0, r_level};

    // The FIFO shares this reset, so the strobe is held low while reset is asserted.
    assign w_issue  = i_rst_n & i_enable & ~bus.i_empty & (w_committed < {1'b0, DEPTH_C});

    assign w_vld    = bus.i_fifo_rddata_vld;
    assign w_tvalid = (r_level != '0);
    assign w_pop    = w_tvalid & bus.i_tready;
    assign w_full   = (r_level == DEPTH_C);

    // When full, a same-cycle pop frees the slot at rd_ptr, which equals wr_ptr,
    // so the incoming word may take it; the outgoing word was already presented.
    assign w_wr     = w_vld & (~w_full | w_pop);
    assign w_ovf    = w_vld & w_full & ~w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_inflight  <= '0;
            r_err_unexp <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            // Issue and return in the same cycle cancel; never go below zero.
            if (w_issue && !w_vld) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (w_vld && !w_issue && (r_inflight != '0)) begin
                r_inflight <= r_inflight - CW'(1);
            end

            if (w_vld && (r_inflight == '0)) begin
                r_err_unexp <= 1'b1;
            end
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            if (w_wr && !w_pop) begin
                r_level <= r_level + CW'(1);
            end else if (w_pop && !w_wr) begin
                r_level <= r_level - CW'(1);
            end
        end
    end

    // Data storage carries no reset; o_tdata is meaningless while o_tvalid=0.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_buf[r_wr_ptr] <= bus.i_fifo_data;
        end
    end

    assign bus.o_fifo_rd = w_issue;
    assign bus.o_tvalid  = w_tvalid;
    assign bus.o_tdata   = r_buf[r_rd_ptr];
    assign o_level       = r_level;
    assign o_inflight    = r_inflight;
    assign o_error_unexp = r_err_unexp;
    assign o_error_ovf   = r_err_ovf;
endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int DW    = 512;
    localparam int RDL   = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] level;
    logic [CW-1:0] inflight;
    logic          err_u;
    logic          err_o;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(RDL), .BUF_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .bus           (bus),
        .o_level       (level),
        .o_inflight    (inflight),
        .o_error_unexp (err_u),
        .o_error_ovf   (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: FIFO contents, pending returns (due cycle + word),
    // words accepted by the adapter in stream order, outstanding read count, sticky errors.
    typedef struct { int c; logic [DW-1:0] d; } ret_t;
    logic [DW-1:0] fifo_q[$];
    ret_t          ret_q[$];
    logic [DW-1:0] sb[$];
    int            m_inflight = 0;
    bit            m_eu = 1'b0;
    bit            m_eo = 1'b0;
    bit            force_empty = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_consumed = 0;
    int n_rd_obs, n_tv_obs, first_rd_cyc, last_rd_cyc, first_tv_cyc, run, max_run;
    logic [DW-1:0] first_tv_dat;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic upd_empty();
        bus.i_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        upd_empty();
    endtask

    task automatic clr_obs();
        n_rd_obs = 0; n_tv_obs = 0; first_rd_cyc = -1; last_rd_cyc = -1;
        first_tv_cyc = -1; run = 0; max_run = 0; first_tv_dat = '0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the
    // rising edge, then present the FIFO's returning data for the next cycle.
    task automatic cycle();
        bit exp_rd, pop, full_before, vld;
        logic [DW-1:0] d;
        ret_t r;
        @(negedge clk);
        exp_rd = rst_n && en && !bus.i_empty && ((m_inflight + sb.size()) < DEPTH);
        chk("fifo_rd",   longint'(bus.o_fifo_rd), longint'(exp_rd));
        chk("tvalid",    longint'(bus.o_tvalid),  longint'(sb.size() != 0));
        chk("level",     longint'(level),         longint'(sb.size()));
        chk("inflight",  longint'(inflight),      longint'(m_inflight));
        chk("err_unexp", longint'(err_u),         longint'(m_eu));
        chk("err_ovf",   longint'(err_o),         longint'(m_eo));
        if (sb.size() != 0) chk_d("tdata", bus.o_tdata, sb[0]);
        if (bus.o_fifo_rd) begin
            n_rd_obs++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
        end
        if (bus.o_tvalid) begin
            if (first_tv_cyc < 0) begin first_tv_cyc = cyc; first_tv_dat = bus.o_tdata; end
            n_tv_obs++; run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        pop = (sb.size() != 0) && bus.i_tready;
        vld = bus.i_fifo_rddata_vld;
        d   = bus.i_fifo_data;
        @(posedge clk);
        if (rst_n) begin
            if (exp_rd) begin
                r.c = cyc + RDL;
                r.d = fifo_q.pop_front();
                ret_q.push_back(r);
            end
            if (vld && m_inflight == 0) m_eu = 1'b1;
            if (exp_rd && !vld) m_inflight++;
            else if (vld && !exp_rd && m_inflight > 0) m_inflight--;
            full_before = (sb.size() == DEPTH);
            if (pop) begin void'(sb.pop_front()); n_consumed++; end
            if (vld) begin
                if (full_before && !pop) m_eo = 1'b1;
                else sb.push_back(d);
            end
            cyc++;
        end
        #1;
        bus.i_fifo_rddata_vld = 1'b0;
        if (ret_q.size() != 0 && ret_q[0].c == cyc) begin
            bus.i_fifo_rddata_vld = 1'b1;
            bus.i_fifo_data = ret_q[0].d;
            void'(ret_q.pop_front());
        end
        upd_empty();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((fifo_q.size() != 0 || sb.size() != 0 || ret_q.size() != 0 || bus.i_fifo_rddata_vld) && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_left", longint'(fifo_q.size() + sb.size() + ret_q.size()), 0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] w_first;
        int base;

        bus.i_empty = 1'b1;
        bus.i_fifo_rddata_vld = 1'b0;
        bus.i_fifo_data = '0;
        bus.i_tready = 1'b0;
        clr_obs();

        // Reset state
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single word 0xA5
        en = 1'b1; bus.i_tready = 1'b1; clr_obs();
        w = '0; w[7:0] = 8'hA5;
        push(w);
        for (int k = 0; k < 8; k++) cycle();
        chk("single_reads", longint'(n_rd_obs), 1);
        chk("single_latency", longint'(first_tv_cyc - last_rd_cyc), 4);
        chk("single_tvalid_cycles", longint'(n_tv_obs), 1);
        chk_d("single_data", first_tv_dat, w);
        chk("single_level_end", longint'(level), 0);

        // Streaming: 100 incrementing words
        clr_obs(); base = n_consumed;
        for (int i = 0; i < 100; i++) begin
            w = rnd_word(); w[31:0] = i;
            push(w);
        end
        for (int k = 0; k < 110; k++) cycle();
        chk("stream_latency", longint'(first_tv_cyc - first_rd_cyc), 4);
        chk("stream_run", longint'(max_run), 100);
        chk("stream_tvalid_cycles", longint'(n_tv_obs), 100);
        chk("stream_consumed", longint'(n_consumed - base), 100);

        // Backpressure: 20 words, sink stalled 30 cycles
        bus.i_tready = 1'b0; clr_obs(); base = n_consumed;
        for (int i = 0; i < 20; i++) push(rnd_word());
        for (int k = 0; k < 30; k++) cycle();
        chk("bp_reads", longint'(n_rd_obs), DEPTH);
        chk("bp_level", longint'(level), DEPTH);
        chk("bp_inflight", longint'(inflight), 0);
        bus.i_tready = 1'b1;
        drain(100);
        chk("bp_consumed", longint'(n_consumed - base), 20);
        chk("bp_err_unexp", longint'(err_u), 0);
        chk("bp_err_ovf", longint'(err_o), 0);

        // Enable gating with 3 reads in flight, then empty gating
        clr_obs(); base = n_consumed;
        for (int i = 0; i < 10; i++) push(rnd_word());
        for (int k = 0; k < 3; k++) cycle();
        en = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        chk("en_reads", longint'(n_rd_obs), 3);
        chk("en_landed", longint'(n_consumed - base), 3);
        en = 1'b1; force_empty = 1'b1; upd_empty();
        for (int k = 0; k < 6; k++) cycle();
        chk("empty_reads", longint'(n_rd_obs), 3);
        force_empty = 1'b0; upd_empty();
        drain(100);
        chk("en_consumed", longint'(n_consumed - base), 10);

        // Unexpected data-valid with nothing in flight
        bus.i_fifo_rddata_vld = 1'b1; bus.i_fifo_data = rnd_word();
        cycle();
        chk("unexp_set", longint'(err_u), 1);
        for (int k = 0; k < 5; k++) cycle();
        chk("unexp_sticky", longint'(err_u), 1);

        // Overflow: full buffer, stalled sink, injected valid
        bus.i_tready = 1'b0;
        for (int i = 0; i < 12; i++) push(rnd_word());
        for (int k = 0; k < 40 && !(sb.size() == DEPTH && m_inflight == 0); k++) cycle();
        chk("ovf_pre_level", longint'(level), DEPTH);
        bus.i_fifo_rddata_vld = 1'b1; bus.i_fifo_data = rnd_word();
        cycle();
        chk("ovf_set", longint'(err_o), 1);
        chk("ovf_level", longint'(level), DEPTH);
        bus.i_tready = 1'b1;
        drain(100);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 3) != 0);
            bus.i_tready = ($urandom_range(0, 9) < 6);
            force_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 30) push(rnd_word());
            upd_empty();
            cycle();
        end
        en = 1'b1; bus.i_tready = 1'b1; force_empty = 1'b0; upd_empty();
        drain(200);

        // Reset mid-burst at level=5, inflight=3
        bus.i_tready = 1'b0;
        for (int i = 0; i < 20; i++) push(rnd_word());
        for (int k = 0; k < 30 && !(sb.size() == 5 && m_inflight == 3); k++) cycle();
        chk("rst_pre_level", longint'(level), 5);
        chk("rst_pre_inflight", longint'(inflight), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_fifo_rd", longint'(bus.o_fifo_rd), 0);
        chk("rst_tvalid", longint'(bus.o_tvalid), 0);
        chk("rst_level", longint'(level), 0);
        chk("rst_inflight", longint'(inflight), 0);
        chk("rst_err_unexp", longint'(err_u), 0);
        chk("rst_err_ovf", longint'(err_o), 0);
        fifo_q.delete(); ret_q.delete(); sb.delete();
        m_inflight = 0; m_eu = 1'b0; m_eo = 1'b0;
        bus.i_fifo_rddata_vld = 1'b0; upd_empty();
        for (int k = 0; k < 3; k++) cycle();
        rst_n = 1'b1;
        bus.i_tready = 1'b1; clr_obs();
        w_first = rnd_word();
        push(w_first);
        push(rnd_word());
        push(rnd_word());
        for (int k = 0; k < 12 && n_tv_obs == 0; k++) cycle();
        chk("post_rst_seen", longint'(n_tv_obs != 0), 1);
        chk_d("post_rst_first", first_tv_dat, w_first);
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
